// File: rtl/float24_pkg.sv
// float24_pkg: shared widths, field positions and entry layout for the 24-bit float datapath.
package float24_pkg;
  localparam int FLT_W = 24;
  localparam int EXP_W = 7;
  localparam int MAN_W = 16;
  localparam int SIGN_BIT = FLT_W - 1;
  localparam int EXP_MSB = SIGN_BIT - 1;
  localparam int EXP_LSB = MAN_W;
  localparam int MAN_MSB = MAN_W - 1;
  localparam int MAN_LSB = 0;
  localparam int ENTRY_W = FLT_W + 2;
  localparam logic [FLT_W-2:0] FLT_MAX_MAG = {7'h7F, 16'hFFFF};
  localparam logic [FLT_W-2:0] FLT_ZERO_MAG = 23'h0;
  typedef struct packed {
    logic ovf;
    logic unf;
    logic [FLT_W-1:0] data;
  } entry_t;
endpackage

// File: rtl/float24_fifo_mem.sv
// float24_fifo_mem: DEPTH-entry result storage with one write port and an asynchronous read port.
module float24_fifo_mem
  import float24_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  entry_t        wdata,
  input  logic [AW-1:0] raddr,
  output entry_t        rdata
);
  entry_t mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/float24_result_buffer.sv
// float24_result_buffer: show-ahead FIFO for multiplier results with sticky exception status and drop counter.
// Optional FLOAT24_SATURATE_EN rewrites overflowed/underflowed words to max magnitude/zero before storage.
module float24_result_buffer
  import float24_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [FLT_W-1:0] in_data,
  input  logic             in_overflow,
  input  logic             in_underflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FLT_W-1:0] out_data,
  output logic             out_overflow,
  output logic             out_underflow,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] drop_count,
  output logic             sticky_ovf,
  output logic             sticky_unf,
  input  logic             clr_status
);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [FLT_W-1:0] wr_data;
  logic [LW-1:0] level_nxt;
  logic push, pop, drop;
  entry_t wr_entry, rd_entry;
  assign push = in_valid && !full;
  assign drop = in_valid && full;
  assign pop = !empty && out_ready;
  assign level_nxt = level + LW'(push) - LW'(pop);
`ifdef FLOAT24_SATURATE_EN
  assign wr_data = in_overflow  ? {in_data[SIGN_BIT], FLT_MAX_MAG} :
                   in_underflow ? {in_data[SIGN_BIT], FLT_ZERO_MAG} : in_data;
`else
  assign wr_data = in_data;
`endif
  assign wr_entry = '{ovf: in_overflow, unf: in_underflow, data: wr_data};
  float24_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      full <= 1'b0;
      empty <= 1'b1;
      drop_count <= '0;
      sticky_ovf <= 1'b0;
      sticky_unf <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      level <= level_nxt;
      full <= level_nxt == LW'(DEPTH);
      empty <= level_nxt == '0;
      drop_count <= clr_status ? CNT_W'(drop) :
                    (drop && !(&drop_count)) ? drop_count + 1'b1 : drop_count;
      sticky_ovf <= (in_valid && in_overflow) || (sticky_ovf && !clr_status);
      sticky_unf <= (in_valid && in_underflow) || (sticky_unf && !clr_status);
    end
  // Mask the head while empty so stale storage never leaks onto the outputs.
  assign out_valid = !empty;
  assign {out_overflow, out_underflow, out_data} = empty ? '0 : rd_entry;
endmodule

// File: tb/tb_float24_result_buffer.sv
// tb_float24_result_buffer: randomized scoreboard bench; queue-based reference model of the result buffer.
module tb_float24_result_buffer;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  logic clk = 0, rst = 1, in_valid = 0, in_overflow = 0, in_underflow = 0, out_ready = 0, clr_status = 0;
  logic [23:0] in_data = 0;
  logic out_valid, out_overflow, out_underflow, full, empty, sticky_ovf, sticky_unf;
  logic [23:0] out_data;
  logic [LW-1:0] level;
  logic [CNT_W-1:0] drop_count;
  int checks = 0, errors = 0;
  logic [25:0] exp_q[$];
  int m_level = 0, m_drop = 0;
  bit m_ovf = 0, m_unf = 0;

  float24_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_overflow(in_overflow), .in_underflow(in_underflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_overflow(out_overflow), .out_underflow(out_underflow),
    .level(level), .full(full), .empty(empty), .drop_count(drop_count),
    .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf), .clr_status(clr_status)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [25:0] model_entry(logic [23:0] d, bit o, bit u);
    logic [23:0] w = d;
`ifdef FLOAT24_SATURATE_EN
    if (o) w = {d[23], 23'h7FFFFF};
    else if (u) w = {d[23], 23'h0};
`endif
    return {o, u, w};
  endfunction

  task automatic step(bit r, bit v, logic [23:0] d, bit o, bit u, bit rdy, bit c);
    bit fullm, psh, drp, pp;
    rst = r; in_valid = v; in_data = d; in_overflow = o; in_underflow = u;
    out_ready = rdy; clr_status = c;
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      m_level = 0; m_drop = 0; m_ovf = 0; m_unf = 0;
    end else begin
      fullm = m_level == DEPTH;
      psh = v && !fullm;
      drp = v && fullm;
      pp = rdy && m_level > 0;
      if (psh) exp_q.push_back(model_entry(d, o, u));
      m_level += int'(psh) - int'(pp);
      if (c) m_drop = drp ? 1 : 0;
      else if (drp && m_drop < CNT_MAX) m_drop++;
      m_ovf = (v && o) || (m_ovf && !c);
      m_unf = (v && u) || (m_unf && !c);
    end
    #1;
    chk("level", 32'(level), 32'(m_level));
    chk("full", 32'(full), 32'(m_level == DEPTH));
    chk("empty", 32'(empty), 32'(m_level == 0));
    chk("out_valid", 32'(out_valid), 32'(m_level > 0));
    chk("drop_count", 32'(drop_count), 32'(m_drop));
    chk("sticky", {30'b0, sticky_ovf, sticky_unf}, {30'b0, m_ovf, m_unf});
  endtask

  // Monitor: every accepted head entry must match the oldest expected word.
  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
      else chk("head", {6'b0, out_overflow, out_underflow, out_data}, {6'b0, exp_q.pop_front()});
    end

  initial begin
    step(1, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    chk("reset_out_data", {5'b0, out_overflow, out_underflow, out_data}, 0);
    step(0, 1, 24'h3F8000, 0, 0, 1, 0);
    step(0, 1, 24'hBF4000, 0, 0, 1, 0);
    step(0, 1, 24'h400001, 0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 24'(32'h100 + i), 0, 0, 0, 0);
    step(0, 1, 24'h555555, 0, 0, 1, 0);
    repeat (9) step(0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 24'h012345, 1, 0, 1, 0);
    step(0, 1, 24'h812345, 0, 1, 1, 0);
    step(0, 1, 24'h8ABCDE, 0, 1, 1, 1);
    step(0, 1, 24'h7ABCDE, 1, 1, 1, 0);
    repeat (2) step(0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 26; i++) step(0, 1, 24'($urandom), 0, 0, 0, 0);
    step(0, 1, 24'h111111, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 24'hC0FFEE, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 499) == 0, $urandom_range(0, 9) < 7, 24'($urandom),
           $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
    for (int i = 0; i < 2 * DEPTH && exp_q.size() > 0; i++) step(0, 0, 0, 0, 0, 1, 0);
    chk("drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/float24_result_buffer.md
# float24_result_buffer

Output buffer for the 24-bit float multiplier datapath (1 sign, 7 exponent, 16 mantissa bits). Sits directly downstream of the multiplier's registered result stage. It captures each result word with its overflow/underflow flags, queues them in a show-ahead FIFO behind a valid/ready handshake, and keeps sticky exception status and a drop counter for results lost while full.

## Interface
- `DEPTH`, default 8: FIFO entries; power of two, ≥ 2.
- `CNT_W`, default 16: width of `drop_count`.

- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: result word present this cycle, aligned with the multiplier's registered outputs.
- `in_data` in 24: float word; [23] sign, [22:16] exponent, [15:0] mantissa.
- `in_overflow` in 1: overflow flag for `in_data`.
- `in_underflow` in 1: underflow flag for `in_data`.
- `out_valid` out 1: head entry available.
- `out_ready` in 1: consumer accepts head entry.
- `out_data` out 24: head float word.
- `out_overflow` out 1: head entry overflow flag.
- `out_underflow` out 1: head entry underflow flag.
- `level` out $clog2(DEPTH)+1: current occupancy.
- `full` out 1: `level == DEPTH`.
- `empty` out 1: `level == 0`.
- `drop_count` out CNT_W: results discarded because the buffer was full.
- `sticky_ovf` out 1: any overflow seen since the last clear.
- `sticky_unf` out 1: any underflow seen since the last clear.
- `clr_status` in 1: clears `drop_count`, `sticky_ovf` and `sticky_unf`.

## Operation
- No input backpressure. The multiplier pipeline cannot stall, so every `in_valid` cycle is either a push or a drop.
- Push: `in_valid && !full` writes {flags, data} at the write pointer, then increments it.
- Drop: `in_valid && full` discards the word and increments `drop_count`. The counter saturates at all-ones and does not wrap.
- `full` is the registered value at the start of the cycle. A push arriving while full with a simultaneous pop is still dropped.
- Pop: `out_valid && out_ready` advances the read pointer. `out_ready` while empty is ignored.
- Simultaneous push and pop (not full, not empty): `level` is unchanged and both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Output is show-ahead: `out_data`, `out_overflow` and `out_underflow` always reflect the head entry while `out_valid` = 1. They are don't-care when empty.
- `out_valid` = !empty.
- Sticky flags set on any `in_valid` carrying the flag, whether the word is pushed or dropped.
- `clr_status` together with a same-cycle set or drop: the new event wins. The flag ends at 1, or the count ends at 1.
- Both input flags set: the entry stores both flags unchanged.

## Timing
- Reset values: `out_valid` 0, `empty` 1, `full` 0, `level` 0, `drop_count` 0, `sticky_ovf` 0, `sticky_unf` 0, `out_data`/flags 0. Pointers are 0.
- Reset mid-operation discards all stored entries. The first cycle after reset accepts pushes.
- Latency: a word pushed at edge N is visible with `out_valid` = 1 after edge N, i.e. in cycle N+1.
- Throughput: one push and one pop per cycle, sustained.
- `level`, `full`, `empty` and status outputs are all registered. They update on the same edge as the push or pop that changes them.

## Configuration
- `FLOAT24_SATURATE_EN` defined: the word is rewritten before storage.
  - `in_overflow` = 1: stored as {sign, 7'h7F, 16'hFFFF}.
  - `in_underflow` = 1 (with overflow = 0): stored as {sign, 7'h00, 16'h0000}.
  - Overflow takes priority when both flags are set.
  - Stored flags are kept unchanged.
- Undefined: `in_data` is stored verbatim.

## Structure
- Shared package `float24_pkg`:
  - widths `FLT_W` = 24, `EXP_W` = 7, `MAN_W` = 16.
  - field index constants.
  - `FLT_MAX_MAG` = {7'h7F, 16'hFFFF}.
  - `FLT_ZERO_MAG` = 23'h0.
  - packed entry typedef {ovf, unf, data}.
- Sub-module `float24_fifo_mem`:
  - DEPTH × 26-bit storage, write port and asynchronous read at the read pointer.
  - Pointers, level, full/empty and status logic stay in the top.

## Test plan
- Reset with `out_ready` = 1, then push 24'h3F8000, 24'hBF4000, 24'h400001 on consecutive cycles → `out_valid` rises one cycle after the first push; outputs appear in order; `level` returns to 0.
- `out_ready` = 0, push 10 words with DEPTH = 8 → `full` = 1 after the 8th push, `drop_count` = 2; popping drains exactly the first 8 words in order.
- Full buffer, push and pop in the same cycle → push dropped, `drop_count` +1, `level` = 7.
- Push `in_data` = 24'h012345 with `in_overflow` = 1:
  - macro defined → `out_data` = 24'h7FFFFF, `sticky_ovf` = 1.
  - macro undefined → `out_data` = 24'h012345, `sticky_ovf` = 1.
- Push a sign-1 word with `in_underflow` = 1 → with the macro, `out_data` = 24'h800000; `clr_status` in the same cycle as a new underflow leaves `sticky_unf` = 1.
- Assert `rst` with 5 entries stored → next cycle `level` = 0, `out_valid` = 0, `drop_count` = 0; a subsequent push is output correctly.
